p521_mersenne_reducer: RTL and testbench

- Word-serial modular reduction stage placed directly downstream of the 521x521 two-way Karatsuba multiplier.
- Consumes the 1042-bit product and returns product mod p, where p = 2^521 - 1 (the NIST P-521 Mersenne prime).
- Uses the Mersenne identity x = hi*2^521 + lo ≡ hi + lo (mod p), computed with a W-bit adder over several cycles to bound area.
- Valid/ready handshakes on both sides; fixed latency.

---
 rtl/p521_mersenne_reducer.sv | 129 ++++++++++++
 tb/tb_p521_mersenne_reducer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/p521_mersenne_reducer.sv
// Word-serial reduction of a 1042-bit product modulo p = 2^521 - 1.
// Uses x = hi*2^521 + lo == hi + lo (mod p), then folds bit 521 back in,
// then maps t == p to 0. All additions run through one W-bit adder.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | waiting for a product; in_ready high
// S_ADD   | s = lo + hi, one word per cycle (N cycles)
// S_FOLD  | t = s[520:0] + s[521], one word per cycle (N cycles)
// S_CHECK | result = (t == p) ? 0 : t
// S_DONE  | result presented with out_valid until out_ready
module p521_mersenne_reducer #(
  parameter int W = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1041:0] product,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [520:0]  result
);

  localparam int N  = (522 + W - 1) / W;
  localparam int NW = N * W;
  localparam int KW = $clog2(N);
  localparam logic [NW-1:0] MASK = {{(NW-521){1'b0}}, {521{1'b1}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADD,
    S_FOLD,
    S_CHECK,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [NW-1:0]   r_lo;
  logic [NW-1:0]   r_hi;
  logic            r_carry;
  logic [KW-1:0]   r_k;
  logic [520:0]    r_result;

  logic [NW-1:0]   w_lo_masked;
  logic            w_last;
  logic [W-1:0]    w_op_a;
  logic [W-1:0]    w_op_b;
  logic            w_cin;
  logic [W:0]      w_sum;

  assign w_lo_masked = r_lo & MASK;
  assign w_last      = (r_k == KW'(N - 1));

  // Adder operand selection: lo+hi+carry while adding, s0+s1 while folding.
  // r_lo[521] (s1) is still intact at k=0 because word 0 never holds bit 521.
  always_comb begin
    w_op_a = r_lo[r_k*W +: W];
    w_op_b = r_hi[r_k*W +: W];
    w_cin  = r_carry;
    if (r_state == S_FOLD) begin
      w_op_a = w_lo_masked[r_k*W +: W];
      w_op_b = '0;
      w_cin  = (r_k == '0) ? r_lo[521] : r_carry;
    end
  end

  assign w_sum = {1'b0, w_op_a} + {1'b0, w_op_b} + {{W{1'b0}}, w_cin};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)  w_next = S_ADD;
      S_ADD:   if (w_last)    w_next = S_FOLD;
      S_FOLD:  if (w_last)    w_next = S_CHECK;
      S_CHECK:                w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default:                w_next = S_IDLE;
    endcase
  end

  // Handshake outputs; in_ready is suppressed while reset is asserted.
  always_comb begin
    in_ready  = (r_state == S_IDLE) && !rst;
    out_valid = (r_state == S_DONE);
  end

  // Datapath: capture, in-place word accumulation in r_lo, final compare.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lo     <= '0;
      r_hi     <= '0;
      r_carry  <= 1'b0;
      r_k      <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_lo    <= NW'(product[520:0]);
            r_hi    <= NW'(product[1041:521]);
            r_carry <= 1'b0;
            r_k     <= '0;
          end
        end
        S_ADD, S_FOLD: begin
          r_lo[r_k*W +: W] <= w_sum[W-1:0];
          r_carry          <= w_sum[W];
          r_k              <= w_last ? '0 : r_k + KW'(1);
        end
        S_CHECK: begin
          r_result <= (&r_lo[520:0]) ? '0 : r_lo[520:0];
        end
        default: ;
      endcase
    end
  end

  assign result = r_result;

endmodule

// File: tb/tb_p521_mersenne_reducer.sv
// Bench for p521_mersenne_reducer: W=64 and W=32 instances exercised in turn
// with directed and random products; expectations come from x % p.
module tb_p521_mersenne_reducer;

  localparam logic [1041:0] P = {521'b0, {521{1'b1}}};

  logic          clk = 1'b0;
  logic          rst  [2];
  logic          vin  [2];
  logic          rdy  [2];
  logic          vout [2];
  logic          ordy [2];
  logic [1041:0] prod [2];
  logic [520:0]  res  [2];

  always #5 clk = ~clk;

  p521_mersenne_reducer #(.W(64)) u_w64 (
    .clk(clk), .rst(rst[0]), .in_valid(vin[0]), .in_ready(rdy[0]),
    .product(prod[0]), .out_valid(vout[0]), .out_ready(ordy[0]), .result(res[0])
  );

  p521_mersenne_reducer #(.W(32)) u_w32 (
    .clk(clk), .rst(rst[1]), .in_valid(vin[1]), .in_ready(rdy[1]),
    .product(prod[1]), .out_valid(vout[1]), .out_ready(ordy[1]), .result(res[1])
  );

  typedef struct {
    logic [520:0] exp;
    int           acc;
  } item_t;

  item_t        sb[$];
  int           n_cmp = 0;
  int           n_err = 0;
  int           cyc   = 0;
  int           act   = 0;
  bit           bp_rand = 1'b0;
  int           lat [2];
  bit           prev_v  = 1'b0;
  bit           prev_hs = 1'b0;
  logic [520:0] held;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [520:0] ref_mod(input logic [1041:0] x);
    logic [1041:0] r;
    r = x % P;
    return r[520:0];
  endfunction

  task automatic check(input string nm, input logic [520:0] got, input logic [520:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, want);
    end
  endtask

  // Monitor: latency, stability under backpressure, scoreboard pop.
  always @(negedge clk) begin
    if (rst[act]) begin
      prev_v  = 1'b0;
      prev_hs = 1'b0;
    end else begin
      if (vout[act] && !prev_v) begin
        if (sb.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_output: got result %0h with nothing outstanding", res[act]);
        end else begin
          check("latency", 521'(cyc - sb[0].acc), 521'(lat[act]));
          check("in_ready_busy", 521'(rdy[act]), 521'(0));
        end
      end
      if (vout[act] && prev_v && !prev_hs)
        check("result_stable", res[act], held);
      if (vout[act] && ordy[act] && sb.size() != 0) begin
        check("result", res[act], sb[0].exp);
        void'(sb.pop_front());
      end
      held    = res[act];
      prev_v  = vout[act];
      prev_hs = vout[act] && ordy[act];
    end
  end

  // Random backpressure, changed well away from both clock edges.
  always @(posedge clk) begin
    #2;
    if (bp_rand) ordy[act] = ($urandom_range(0, 3) != 0);
  end

  task automatic send(input int d, input logic [1041:0] x, input bit expect_it);
    int n;
    n = 0;
    @(negedge clk);
    prod[d] = x;
    vin[d]  = 1'b1;
    while (!rdy[d] && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      n_cmp++; n_err++;
      $display("FAIL accept_timeout: in_ready stayed %0b, required 1", rdy[d]);
      vin[d] = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    if (expect_it) sb.push_back('{exp: ref_mod(x), acc: cyc});
    vin[d] = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL drain_timeout: %0d outstanding, required 0", sb.size());
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic run_dut(input int d);
    logic [1041:0] x;
    int            n;
    act     = d;
    ordy[d] = 1'b1;
    vin[d]  = 1'b0;
    rst[d]  = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", 521'(rdy[d]), 521'(0));
    check("rst_out_valid", 521'(vout[d]), 521'(0));
    check("rst_result", res[d], '0);
    @(negedge clk);
    rst[d] = 1'b0;
    #1;
    check("in_ready_after_rst", 521'(rdy[d]), 521'(1));

    // Directed boundary vectors
    send(d, '0, 1'b1);
    send(d, P, 1'b1);
    x = '0; x[521] = 1'b1;
    send(d, x, 1'b1);
    send(d, '1, 1'b1);
    x = P - 1;
    send(d, x * x, 1'b1);
    x = '0; x[521] = 1'b1;
    send(d, x + P - 1, 1'b1);
    drain();

    // Backpressure with ignored in_valid pulses while busy
    @(posedge clk); #1;
    ordy[d] = 1'b0;
    send(d, {$urandom, $urandom, $urandom, 1010'd12345}, 1'b1);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      vin[d]  = i[0];
      prod[d] = {33{$urandom}};
    end
    vin[d] = 1'b0;
    n = 0;
    while (!vout[d] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!vout[d]) begin
      n_cmp++; n_err++;
      $display("FAIL bp_out_valid_timeout: out_valid %0b, required 1", vout[d]);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_in_ready", 521'(rdy[d]), 521'(0));
    end
    @(posedge clk); #1;
    ordy[d] = 1'b1;
    @(posedge clk); #1;
    check("in_ready_after_hs", 521'(rdy[d]), 521'(1));
    send(d, (P - 7) * 3 + 1042'd9, 1'b1);
    drain();

    // Abort mid-ADD via reset, then a fresh product
    send(d, '1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst[d] = 1'b1;
    @(posedge clk); #1;
    rst[d] = 1'b0;
    check("abort_result", res[d], '0);
    for (int i = 0; i < 4 * lat[d]; i++) begin
      @(negedge clk);
      if (vout[d]) begin
        n_cmp++; n_err++;
        $display("FAIL abort_out_valid: got 1 required 0 at cycle %0d", cyc);
        break;
      end
    end
    n_cmp++;
    x = '0; x[521] = 1'b1; x = x + 5;
    check("ref_model_2p521_plus5", ref_mod(x), 521'd6);
    send(d, x, 1'b1);
    drain();

    // Random products under random backpressure
    bp_rand = 1'b1;
    for (int i = 0; i < 25; i++) begin
      for (int j = 0; j < 33; j++) x[j*32 +: 32] = $urandom;
      case ($urandom_range(0, 3))
        0: x[1041:521] = '1;
        1: x[520:0]    = '1;
        2: x[1041:521] = 521'($urandom_range(0, 2));
        default: ;
      endcase
      send(d, x, 1'b1);
    end
    drain();
    bp_rand = 1'b0;
    @(posedge clk); #1;
    ordy[d] = 1'b1;
    rst[d]  = 1'b1;
  endtask

  initial begin
    lat[0] = 2 * ((522 + 63) / 64) + 1;
    lat[1] = 2 * ((522 + 31) / 32) + 1;
    for (int d = 0; d < 2; d++) begin
      rst[d]  = 1'b1;
      vin[d]  = 1'b0;
      ordy[d] = 1'b1;
      prod[d] = '0;
    end
    run_dut(0);
    run_dut(1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
